// File: rtl/pong_game_engine_if.sv
// Game-state bus between the pong engine and its surroundings: player/timing
// inputs in, paddle/ball/score state out.
interface pong_game_engine_if;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned SCORE_W = 4;

  logic               frame_tick;
  logic               p1_up;
  logic               p1_down;
  logic               p2_up;
  logic               p2_down;
  logic               start;
  logic [COORD_W-1:0] paddle_1;
  logic [COORD_W-1:0] paddle_2;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic [1:0]         state;
  logic               point_pulse;

  modport master (
    output frame_tick, p1_up, p1_down, p2_up, p2_down, start,
    input  paddle_1, paddle_2, ball_x, ball_y, score_1, score_2, state, point_pulse
  );

  modport slave (
    input  frame_tick, p1_up, p1_down, p2_up, p2_down, start,
    output paddle_1, paddle_2, ball_x, ball_y, score_1, score_2, state, point_pulse
  );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game-state engine: per-frame paddle/ball motion, bounces, misses,
// scoring and the idle/play/point/game-over sequence.
module pong_game_engine #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_X1   = 16,
  parameter int unsigned PADDLE_X2   = 616,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned PADDLE_STEP = 4,
  parameter int unsigned BALL_STEP   = 2,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned POINT_DELAY = 60
) (
  input logic               clk,
  input logic               reset,
  pong_game_engine_if.slave bus
);
  localparam int unsigned COORD_W = 12;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = $clog2(POINT_DELAY + 1);

  localparam logic [COORD_W-1:0] PADDLE_MAX   = COORD_W'(V_ACTIVE - PADDLE_H);
  localparam logic [COORD_W-1:0] PADDLE_RESET = COORD_W'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [COORD_W-1:0] BALL_X0      = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_Y0      = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_Y_MAX   = COORD_W'(V_ACTIVE - BALL_SIZE);
  localparam logic [COORD_W-1:0] FACE_L       = COORD_W'(PADDLE_X1 + PADDLE_W);
  localparam logic [COORD_W-1:0] FACE_R       = COORD_W'(PADDLE_X2 - BALL_SIZE);
  localparam logic [COORD_W-1:0] MISS_R       = COORD_W'(H_ACTIVE - BALL_SIZE - BALL_STEP);
  localparam logic [COORD_W-1:0] P_STEP       = COORD_W'(PADDLE_STEP);
  localparam logic [COORD_W-1:0] B_STEP       = COORD_W'(BALL_STEP);
  localparam logic [COORD_W-1:0] B_SIZE       = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] P_HEIGHT     = COORD_W'(PADDLE_H);
  localparam logic [SCORE_W-1:0] WIN          = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(POINT_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_POINT    = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic               dx_q, dx_d, dy_q, dy_d;   // 1 = moving right / down
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pp_q, pp_d;
  logic               start_q;

  logic               start_rise;
  logic               ov1, ov2;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  assign start_rise = bus.start & ~start_q;
  assign ov1 = (by_q + B_SIZE > p1_q) && (by_q < p1_q + P_HEIGHT);
  assign ov2 = (by_q + B_SIZE > p2_q) && (by_q < p2_q + P_HEIGHT);
  assign s1_inc = (s1_q == SCORE_MAX) ? s1_q : s1_q + SCORE_W'(1);
  assign s2_inc = (s2_q == SCORE_MAX) ? s2_q : s2_q + SCORE_W'(1);

  // Paddle step with clamping; opposing buttons cancel.
  function automatic logic [COORD_W-1:0] step_paddle(logic [COORD_W-1:0] y, logic up, logic dn);
    if (up && !dn) return (y >= P_STEP) ? y - P_STEP : '0;
    if (dn && !up) return (y + P_STEP >= PADDLE_MAX) ? PADDLE_MAX : y + P_STEP;
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      p1_q    <= PADDLE_RESET;
      p2_q    <= PADDLE_RESET;
      bx_q    <= BALL_X0;
      by_q    <= BALL_Y0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      pp_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;
    pp_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.frame_tick) begin
          p1_d = step_paddle(p1_q, bus.p1_up, bus.p1_down);
          p2_d = step_paddle(p2_q, bus.p2_up, bus.p2_down);
          if (dy_q && (by_q + B_STEP >= BALL_Y_MAX)) begin
            by_d = BALL_Y_MAX;
            dy_d = 1'b0;
          end else if (!dy_q && (by_q <= B_STEP)) begin
            by_d = '0;
            dy_d = 1'b1;
          end else begin
            by_d = dy_q ? by_q + B_STEP : by_q - B_STEP;
          end
          // A miss overrides the vertical step by recentring; dy is kept.
          if (!dx_q) begin
            if ((bx_q <= FACE_L + B_STEP) && (bx_q >= FACE_L) && ov1) begin
              bx_d = FACE_L;
              dx_d = 1'b1;
            end else if (bx_q <= B_STEP) begin
              s2_d    = s2_inc;
              pp_d    = 1'b1;
              bx_d    = BALL_X0;
              by_d    = BALL_Y0;
              dx_d    = 1'b0;
              cnt_d   = '0;
              state_d = (s2_inc == WIN) ? S_GAMEOVER : S_POINT;
            end else begin
              bx_d = bx_q - B_STEP;
            end
          end else begin
            if ((bx_q + B_STEP >= FACE_R) && (bx_q <= FACE_R) && ov2) begin
              bx_d = FACE_R;
              dx_d = 1'b0;
            end else if (bx_q >= MISS_R) begin
              s1_d    = s1_inc;
              pp_d    = 1'b1;
              bx_d    = BALL_X0;
              by_d    = BALL_Y0;
              dx_d    = 1'b1;
              cnt_d   = '0;
              state_d = (s1_inc == WIN) ? S_GAMEOVER : S_POINT;
            end else begin
              bx_d = bx_q + B_STEP;
            end
          end
        end
      end
      S_POINT: begin
        if (bus.frame_tick) begin
          p1_d = step_paddle(p1_q, bus.p1_up, bus.p1_down);
          p2_d = step_paddle(p2_q, bus.p2_up, bus.p2_down);
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GAMEOVER: begin
        if (start_rise) begin
          state_d = S_IDLE;
          s1_d    = '0;
          s2_d    = '0;
          p1_d    = PADDLE_RESET;
          p2_d    = PADDLE_RESET;
          bx_d    = BALL_X0;
          by_d    = BALL_Y0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.paddle_1    = p1_q;
  assign bus.paddle_2    = p2_q;
  assign bus.ball_x      = bx_q;
  assign bus.ball_y      = by_q;
  assign bus.score_1     = s1_q;
  assign bus.score_2     = s2_q;
  assign bus.state       = state_q;
  assign bus.point_pulse = pp_q;
endmodule

// File: tb/tb_pong_game_engine.sv
// Scoreboard bench for pong_game_engine: a frame-level game model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_pong_game_engine;
  logic clk = 1'b0;
  logic reset;

  pong_game_engine_if bus ();
  pong_game_engine dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int st, p1, p2, bx, by, s1, s2, pp;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference game state, plain integers with signed directions.
  int m_st, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_pp, m_cnt;
  bit m_sq;

  bit u1, d1, u2, d2, st_lvl;

  function automatic int pmove(int p, bit up, bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  task automatic award(input int who);
    bit win;
    if (who == 1) begin
      m_s1 = (m_s1 + 1 > 15) ? 15 : m_s1 + 1;
      win  = (m_s1 == 9);
      m_dx = 1;
    end else begin
      m_s2 = (m_s2 + 1 > 15) ? 15 : m_s2 + 1;
      win  = (m_s2 == 9);
      m_dx = -1;
    end
    m_pp  = 1;
    m_bx  = 316;
    m_by  = 236;
    m_cnt = 0;
    m_st  = win ? 3 : 2;
  endtask

  task automatic model_step(input bit tick, input bit st, input bit rst,
                            input bit a1, input bit b1, input bit a2, input bit b2);
    bit rise, ov1, ov2;
    m_pp = 0;
    if (rst) begin
      m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236;
      m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_sq = 0;
      return;
    end
    rise = st && !m_sq;
    m_sq = st;
    if (m_st == 0) begin
      if (rise) m_st = 1;
    end else if (m_st == 1 && tick) begin
      ov1 = (m_by + 8 > m_p1) && (m_by < m_p1 + 64);
      ov2 = (m_by + 8 > m_p2) && (m_by < m_p2 + 64);
      m_p1 = pmove(m_p1, a1, b1);
      m_p2 = pmove(m_p2, a2, b2);
      if (m_dy > 0 && m_by + 2 >= 472) begin m_by = 472; m_dy = -1; end
      else if (m_dy < 0 && m_by <= 2) begin m_by = 0; m_dy = 1; end
      else m_by = m_by + 2 * m_dy;
      if (m_dx < 0) begin
        if (m_bx - 2 <= 24 && m_bx >= 24 && ov1) begin m_bx = 24; m_dx = 1; end
        else if (m_bx <= 2) award(2);
        else m_bx = m_bx - 2;
      end else begin
        if (m_bx + 2 >= 608 && m_bx <= 608 && ov2) begin m_bx = 608; m_dx = -1; end
        else if (m_bx >= 630) award(1);
        else m_bx = m_bx + 2;
      end
    end else if (m_st == 2 && tick) begin
      m_p1 = pmove(m_p1, a1, b1);
      m_p2 = pmove(m_p2, a2, b2);
      m_cnt++;
      if (m_cnt == 60) begin m_st = 1; m_cnt = 0; end
    end else if (m_st == 3 && rise) begin
      m_st = 0; m_s1 = 0; m_s2 = 0; m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236;
    end
  endtask

  // One clock of stimulus; the predicted post-edge outputs go to the scoreboard.
  task automatic cyc(input bit tick, input bit st, input bit rst);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.frame_tick = tick;
    bus.start      = st;
    bus.p1_up      = u1;
    bus.p1_down    = d1;
    bus.p2_up      = u2;
    bus.p2_down    = d2;
    model_step(tick, st, rst, u1, d1, u2, d2);
    e.st = m_st; e.p1 = m_p1; e.p2 = m_p2; e.bx = m_bx; e.by = m_by;
    e.s1 = m_s1; e.s2 = m_s2; e.pp = m_pp;
    exp_q.push_back(e);
  endtask

  task automatic frame(input int gap);
    cyc(1'b1, st_lvl, 1'b0);
    repeat (gap) cyc(1'b0, st_lvl, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: every driven cycle yields one registered output set after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state", int'(bus.state), e.st);
        chk("paddle_1", int'(bus.paddle_1), e.p1);
        chk("paddle_2", int'(bus.paddle_2), e.p2);
        chk("ball_x", int'(bus.ball_x), e.bx);
        chk("ball_y", int'(bus.ball_y), e.by);
        chk("score_1", int'(bus.score_1), e.s1);
        chk("score_2", int'(bus.score_2), e.s2);
        chk("point_pulse", int'(bus.point_pulse), e.pp);
      end
    end
  end

  task automatic track_buttons(input bit p2_tracks);
    int target;
    u1 = (m_p1 + 28 > m_by + 2);
    d1 = (m_p1 + 28 < m_by - 2);
    if (p2_tracks) begin
      u2 = (m_p2 + 28 > m_by + 2);
      d2 = (m_p2 + 28 < m_by - 2);
    end else begin
      target = (m_by < 236) ? 416 : 0;
      u2 = (m_p2 > target);
      d2 = (m_p2 < target);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.p1_up = 1'b0; bus.p1_down = 1'b0; bus.p2_up = 1'b0; bus.p2_down = 1'b0;
    {u1, d1, u2, d2, st_lvl} = '0;

    repeat (2) cyc(1'b0, 1'b0, 1'b1);

    // Idle: buttons must not move anything.
    repeat (5) begin
      {u1, d1, u2, d2} = 4'($urandom);
      frame(1);
    end

    // Start edge coinciding with a tick: no motion on that tick.
    {u1, d1, u2, d2} = 4'b1010;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Paddle 1 saturation at both ends.
    {u1, d1} = 2'b10;
    repeat (60) begin {u2, d2} = 2'($urandom); frame(1); end
    {u1, d1} = 2'b01;
    repeat (110) begin {u2, d2} = 2'($urandom); frame(1); end

    // Player 1 returns everything, player 2 dodges: run to a game-over.
    st_lvl = 1'b0;
    for (int i = 0; i < 20000 && m_st != 3; i++) begin
      track_buttons(1'b0);
      frame(1);
    end

    // Game-over freeze, then a held start gives exactly one transition to idle.
    {u1, d1, u2, d2} = 4'b0101;
    repeat (3) frame(1);
    st_lvl = 1'b1;
    repeat (5) frame(1);
    st_lvl = 1'b0;
    frame(1);
    st_lvl = 1'b1;
    frame(1);
    st_lvl = 1'b0;

    // Rallies with both paddles tracking, then free random play.
    repeat (700) begin track_buttons(1'b1); frame(1); end
    repeat (1500) begin
      {u1, d1, u2, d2} = 4'($urandom);
      st_lvl = ($urandom_range(0, 31) == 0);
      frame($urandom_range(1, 3));
    end
    st_lvl = 1'b0;

    // Reset in the middle of play, together with a tick.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    {u1, d1, u2, d2} = 4'b1001;
    repeat (5) frame(1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
